soft_error_monitor: RTL and testbench

SOFT_ERROR_MONITOR -- requirements
Module: soft_error_monitor

---
 rtl/soft_error_monitor_pkg.sv | 20 ++
 rtl/soft_error_counter.sv | 65 ++++++
 rtl/soft_error_monitor.sv | 107 ++++++++++
 tb/tb_soft_error_monitor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soft_error_monitor_pkg.sv
// soft_error_monitor_pkg
// Shared definitions for the soft error monitor:
//   - CNT_WIDTH_DEFAULT : default width of every count and threshold
//   - ST_*              : per-channel state encoding (IDLE / ARMED / TRIPPED)
//   - TRIP_*            : codes reported on first_trip
package soft_error_monitor_pkg;

  localparam int CNT_WIDTH_DEFAULT = 32;

  // ST_IDLE is all zeros so that reset leaves every channel in IDLE.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_TRIPPED = 2'd2;

  localparam logic [1:0] TRIP_NONE          = 2'd0;
  localparam logic [1:0] TRIP_DATA_CORRUPT  = 2'd1;
  localparam logic [1:0] TRIP_UNKNOWN_TTC   = 2'd2;
  localparam logic [1:0] TRIP_DDR3_OVERFLOW = 2'd3;

endpackage

// File: rtl/soft_error_counter.sv
// soft_error_counter
// One error channel: a saturating event counter plus its IDLE/ARMED/TRIPPED
// state machine.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   hit         : one-cycle event pulse, counted on the clk edge
//   thres       : trip threshold, 0 disables tripping
//   clear       : one-cycle pulse; zeroes count and drops the flag
//   count       : registered, saturating event count
//   flag        : sticky hard-error flag (channel is TRIPPED)
//   trip        : high in the cycle whose closing edge enters TRIPPED
module soft_error_counter
  import soft_error_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hit,
  input  logic [CNT_WIDTH-1:0] thres,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 flag,
  output logic                 trip
);

  logic [1:0] state;
  logic [1:0] idle_or_armed;

  // Compare against the registered count, so a trip lands one edge after the
  // count reaches the threshold. A zero threshold never trips, even in the
  // cycle the threshold drops to zero from ARMED.
  assign trip = (state == ST_ARMED) && (thres != '0) && (count >= thres) && !clear;

  assign idle_or_armed = (thres != '0) ? ST_ARMED : ST_IDLE;
  assign flag          = (state == ST_TRIPPED);

  // Clear beats a coincident event, so that event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (hit && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // TRIPPED is left only through clear or reset. Otherwise the channel follows
  // the threshold between IDLE and ARMED every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= idle_or_armed;
    end else if (state == ST_TRIPPED) begin
      state <= ST_TRIPPED;
    end else if (trip) begin
      state <= ST_TRIPPED;
    end else begin
      state <= idle_or_armed;
    end
  end

endmodule

// File: rtl/soft_error_monitor.sv
// soft_error_monitor
// Counts three classes of soft error (checksum mismatch, unknown TTC command,
// DDR3 overflow), raises a sticky flag per channel when its threshold is
// reached, records which channel tripped first, and ORs the flags together.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   cs_mismatch, unknown_cmd,
//   ddr3_overflow                   : one-cycle event pulses (already in clk domain)
//   thres_*                         : per-channel trip threshold, 0 disables
//   clear_counts                    : one-cycle pulse, clears counts/flags/first_trip
//   *_count                         : per-channel saturating counts
//   error_*                         : per-channel sticky error flags
//   first_trip                      : 0 none, 1 data_corrupt, 2 unknown_ttc, 3 ddr3_overflow
//   any_error                       : registered OR of the three flags
module soft_error_monitor
  import soft_error_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_mismatch,
  input  logic                 unknown_cmd,
  input  logic                 ddr3_overflow,
  input  logic [CNT_WIDTH-1:0] thres_data_corrupt,
  input  logic [CNT_WIDTH-1:0] thres_unknown_ttc,
  input  logic [CNT_WIDTH-1:0] thres_ddr3_overflow,
  input  logic                 clear_counts,
  output logic [CNT_WIDTH-1:0] cs_mismatch_count,
  output logic [CNT_WIDTH-1:0] unknown_cmd_count,
  output logic [CNT_WIDTH-1:0] ddr3_overflow_count,
  output logic                 error_data_corrupt,
  output logic                 error_unknown_ttc,
  output logic                 error_ddr3_overflow,
  output logic [1:0]           first_trip,
  output logic                 any_error
);

  logic trip_data_corrupt;
  logic trip_unknown_ttc;
  logic trip_ddr3_overflow;

  soft_error_counter #(.CNT_WIDTH(CNT_WIDTH)) u_data_corrupt (
    .clk   (clk),
    .reset (reset),
    .hit   (cs_mismatch),
    .thres (thres_data_corrupt),
    .clear (clear_counts),
    .count (cs_mismatch_count),
    .flag  (error_data_corrupt),
    .trip  (trip_data_corrupt)
  );

  soft_error_counter #(.CNT_WIDTH(CNT_WIDTH)) u_unknown_ttc (
    .clk   (clk),
    .reset (reset),
    .hit   (unknown_cmd),
    .thres (thres_unknown_ttc),
    .clear (clear_counts),
    .count (unknown_cmd_count),
    .flag  (error_unknown_ttc),
    .trip  (trip_unknown_ttc)
  );

  soft_error_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ddr3_overflow (
    .clk   (clk),
    .reset (reset),
    .hit   (ddr3_overflow),
    .thres (thres_ddr3_overflow),
    .clear (clear_counts),
    .count (ddr3_overflow_count),
    .flag  (error_ddr3_overflow),
    .trip  (trip_ddr3_overflow)
  );

  // Latched on the same edge that sets the flag, so first_trip and the flag
  // rise together. Only written while empty; priority resolves simultaneous
  // trips.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_trip <= TRIP_NONE;
    end else if (clear_counts) begin
      first_trip <= TRIP_NONE;
    end else if (first_trip == TRIP_NONE) begin
      if (trip_data_corrupt) begin
        first_trip <= TRIP_DATA_CORRUPT;
      end else if (trip_unknown_ttc) begin
        first_trip <= TRIP_UNKNOWN_TTC;
      end else if (trip_ddr3_overflow) begin
        first_trip <= TRIP_DDR3_OVERFLOW;
      end
    end
  end

  // One cycle behind the flags; clear forces it low on the same edge the
  // flags drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_error <= 1'b0;
    end else if (clear_counts) begin
      any_error <= 1'b0;
    end else begin
      any_error <= error_data_corrupt | error_unknown_ttc | error_ddr3_overflow;
    end
  end

endmodule

// File: tb/tb_soft_error_monitor.sv
// tb_soft_error_monitor
// Directed self-checking bench for soft_error_monitor, built with a 12-bit
// count width so saturation is reachable in a few thousand cycles.
module tb_soft_error_monitor;

  localparam int W = 12;

  logic         clk;
  logic         reset;
  logic         cs_mismatch;
  logic         unknown_cmd;
  logic         ddr3_overflow;
  logic [W-1:0] thres_data_corrupt;
  logic [W-1:0] thres_unknown_ttc;
  logic [W-1:0] thres_ddr3_overflow;
  logic         clear_counts;
  logic [W-1:0] cs_mismatch_count;
  logic [W-1:0] unknown_cmd_count;
  logic [W-1:0] ddr3_overflow_count;
  logic         error_data_corrupt;
  logic         error_unknown_ttc;
  logic         error_ddr3_overflow;
  logic [1:0]   first_trip;
  logic         any_error;

  int n_checks;
  int n_fail;

  soft_error_monitor #(.CNT_WIDTH(W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cs_mismatch         (cs_mismatch),
    .unknown_cmd         (unknown_cmd),
    .ddr3_overflow       (ddr3_overflow),
    .thres_data_corrupt  (thres_data_corrupt),
    .thres_unknown_ttc   (thres_unknown_ttc),
    .thres_ddr3_overflow (thres_ddr3_overflow),
    .clear_counts        (clear_counts),
    .cs_mismatch_count   (cs_mismatch_count),
    .unknown_cmd_count   (unknown_cmd_count),
    .ddr3_overflow_count (ddr3_overflow_count),
    .error_data_corrupt  (error_data_corrupt),
    .error_unknown_ttc   (error_unknown_ttc),
    .error_ddr3_overflow (error_ddr3_overflow),
    .first_trip          (first_trip),
    .any_error           (any_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs are driven and
  // outputs sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clears everything with all thresholds at zero so each test starts clean.
  task automatic quiesce();
    thres_data_corrupt  = '0;
    thres_unknown_ttc   = '0;
    thres_ddr3_overflow = '0;
    cs_mismatch   = 1'b0;
    unknown_cmd   = 1'b0;
    ddr3_overflow = 1'b0;
    clear_counts  = 1'b1;
    step();
    clear_counts  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    step();
    n_checks++; if (cs_mismatch_count !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_cs_count: got %0d expected 0", cs_mismatch_count); end
    n_checks++; if (unknown_cmd_count !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_ut_count: got %0d expected 0", unknown_cmd_count); end
    n_checks++; if (ddr3_overflow_count !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_dd_count: got %0d expected 0", ddr3_overflow_count); end
    n_checks++; if ({error_data_corrupt, error_unknown_ttc, error_ddr3_overflow} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {error_data_corrupt, error_unknown_ttc, error_ddr3_overflow}); end
    n_checks++; if (first_trip !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_first_trip: got %0d expected 0", first_trip); end
    n_checks++; if (any_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_any_error: got %b expected 0", any_error); end
  endtask

  // Threshold 3, pulses every other cycle: count 1,2,3 one cycle after each
  // pulse, flag one cycle after count 3, any_error one cycle after the flag.
  task automatic test_threshold_trip();
    $display("[TB] test_threshold_trip");
    thres_data_corrupt = 12'd3;
    step();
    for (int i = 1; i <= 3; i++) begin
      cs_mismatch = 1'b1;
      step();
      cs_mismatch = 1'b0;
      n_checks++; if (cs_mismatch_count !== 12'(i)) begin n_fail++; $display("[TB] FAIL trip_count_%0d: got %0d expected %0d", i, cs_mismatch_count, i); end
      n_checks++; if (error_data_corrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL trip_flag_early_%0d: got %b expected 0", i, error_data_corrupt); end
      if (i < 3) step();
    end
    step();
    n_checks++; if (error_data_corrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL trip_flag: got %b expected 1", error_data_corrupt); end
    n_checks++; if (first_trip !== 2'd1) begin n_fail++; $display("[TB] FAIL trip_first_trip: got %0d expected 1", first_trip); end
    n_checks++; if (any_error !== 1'b0) begin n_fail++; $display("[TB] FAIL trip_any_error_early: got %b expected 0", any_error); end
    step();
    n_checks++; if (any_error !== 1'b1) begin n_fail++; $display("[TB] FAIL trip_any_error: got %b expected 1", any_error); end
  endtask

  // Entered with data_corrupt TRIPPED at count 3: clear and an event in the
  // same cycle leave count 0 and every flag low.
  task automatic test_clear_coincident();
    $display("[TB] test_clear_coincident");
    clear_counts = 1'b1;
    cs_mismatch  = 1'b1;
    step();
    clear_counts = 1'b0;
    cs_mismatch  = 1'b0;
    n_checks++; if (cs_mismatch_count !== 12'd0) begin n_fail++; $display("[TB] FAIL clear_count: got %0d expected 0", cs_mismatch_count); end
    n_checks++; if (error_data_corrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_flag: got %b expected 0", error_data_corrupt); end
    n_checks++; if (first_trip !== 2'd0) begin n_fail++; $display("[TB] FAIL clear_first_trip: got %0d expected 0", first_trip); end
    n_checks++; if (any_error !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_any_error: got %b expected 0", any_error); end
    step();
    n_checks++; if (error_data_corrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_flag_stays: got %b expected 0", error_data_corrupt); end
  endtask

  // unknown_ttc and ddr3_overflow reach threshold 2 together; priority gives 2.
  task automatic test_simultaneous_trip();
    $display("[TB] test_simultaneous_trip");
    quiesce();
    thres_unknown_ttc   = 12'd2;
    thres_ddr3_overflow = 12'd2;
    unknown_cmd   = 1'b1;
    ddr3_overflow = 1'b1;
    step();
    step();
    unknown_cmd   = 1'b0;
    ddr3_overflow = 1'b0;
    n_checks++; if (unknown_cmd_count !== 12'd2) begin n_fail++; $display("[TB] FAIL sim_ut_count: got %0d expected 2", unknown_cmd_count); end
    n_checks++; if (ddr3_overflow_count !== 12'd2) begin n_fail++; $display("[TB] FAIL sim_dd_count: got %0d expected 2", ddr3_overflow_count); end
    step();
    n_checks++; if ({error_data_corrupt, error_unknown_ttc, error_ddr3_overflow} !== 3'b011) begin n_fail++; $display("[TB] FAIL sim_flags: got %b expected 011", {error_data_corrupt, error_unknown_ttc, error_ddr3_overflow}); end
    n_checks++; if (first_trip !== 2'd2) begin n_fail++; $display("[TB] FAIL sim_first_trip: got %0d expected 2", first_trip); end
  endtask

  // Lowering the threshold below the count trips on the next edge; dropping it
  // to 0 afterwards leaves the flag set.
  task automatic test_threshold_lower();
    $display("[TB] test_threshold_lower");
    quiesce();
    thres_data_corrupt = 12'd10;
    cs_mismatch = 1'b1;
    step();
    step();
    cs_mismatch = 1'b0;
    step();
    n_checks++; if (error_data_corrupt !== 1'b0) begin n_fail++; $display("[TB] FAIL lower_flag_armed: got %b expected 0", error_data_corrupt); end
    thres_data_corrupt = 12'd1;
    step();
    n_checks++; if (error_data_corrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL lower_flag_trip: got %b expected 1", error_data_corrupt); end
    n_checks++; if (first_trip !== 2'd1) begin n_fail++; $display("[TB] FAIL lower_first_trip: got %0d expected 1", first_trip); end
    thres_data_corrupt = 12'd0;
    step();
    step();
    n_checks++; if (error_data_corrupt !== 1'b1) begin n_fail++; $display("[TB] FAIL lower_flag_sticky: got %b expected 1", error_data_corrupt); end
  endtask

  // All thresholds 0: 1000 pulses on each channel, no flags.
  task automatic test_idle_counting();
    $display("[TB] test_idle_counting");
    quiesce();
    cs_mismatch   = 1'b1;
    unknown_cmd   = 1'b1;
    ddr3_overflow = 1'b1;
    repeat (1000) step();
    cs_mismatch   = 1'b0;
    unknown_cmd   = 1'b0;
    ddr3_overflow = 1'b0;
    step();
    step();
    n_checks++; if (cs_mismatch_count !== 12'd1000) begin n_fail++; $display("[TB] FAIL idle_cs_count: got %0d expected 1000", cs_mismatch_count); end
    n_checks++; if (unknown_cmd_count !== 12'd1000) begin n_fail++; $display("[TB] FAIL idle_ut_count: got %0d expected 1000", unknown_cmd_count); end
    n_checks++; if (ddr3_overflow_count !== 12'd1000) begin n_fail++; $display("[TB] FAIL idle_dd_count: got %0d expected 1000", ddr3_overflow_count); end
    n_checks++; if ({error_data_corrupt, error_unknown_ttc, error_ddr3_overflow, any_error} !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_flags: got %b expected 0000", {error_data_corrupt, error_unknown_ttc, error_ddr3_overflow, any_error}); end
  endtask

  // 4095 pulses reach all-ones; further pulses must not wrap.
  task automatic test_saturation();
    $display("[TB] test_saturation");
    quiesce();
    ddr3_overflow = 1'b1;
    repeat (4095) step();
    n_checks++; if (ddr3_overflow_count !== 12'hFFF) begin n_fail++; $display("[TB] FAIL sat_full: got %0d expected 4095", ddr3_overflow_count); end
    step();
    ddr3_overflow = 1'b0;
    step();
    n_checks++; if (ddr3_overflow_count !== 12'hFFF) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d expected 4095", ddr3_overflow_count); end
  endtask

  // Reset asserted between edges clears outputs without waiting for clk;
  // counting restarts from zero afterwards.
  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    quiesce();
    thres_unknown_ttc = 12'd1;
    cs_mismatch = 1'b1;
    unknown_cmd = 1'b1;
    step();
    step();
    cs_mismatch = 1'b0;
    unknown_cmd = 1'b0;
    step();
    n_checks++; if (error_unknown_ttc !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre_flag: got %b expected 1", error_unknown_ttc); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (cs_mismatch_count !== 12'd0) begin n_fail++; $display("[TB] FAIL areset_cs_count: got %0d expected 0", cs_mismatch_count); end
    n_checks++; if (unknown_cmd_count !== 12'd0) begin n_fail++; $display("[TB] FAIL areset_ut_count: got %0d expected 0", unknown_cmd_count); end
    n_checks++; if ({error_data_corrupt, error_unknown_ttc, error_ddr3_overflow} !== 3'b000) begin n_fail++; $display("[TB] FAIL areset_flags: got %b expected 000", {error_data_corrupt, error_unknown_ttc, error_ddr3_overflow}); end
    n_checks++; if (first_trip !== 2'd0) begin n_fail++; $display("[TB] FAIL areset_first_trip: got %0d expected 0", first_trip); end
    n_checks++; if (any_error !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_any_error: got %b expected 0", any_error); end
    #1;
    reset = 1'b0;
    thres_unknown_ttc = 12'd0;
    step();
    cs_mismatch = 1'b1;
    step();
    cs_mismatch = 1'b0;
    n_checks++; if (cs_mismatch_count !== 12'd1) begin n_fail++; $display("[TB] FAIL areset_resume: got %0d expected 1", cs_mismatch_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset               = 1'b1;
    cs_mismatch         = 1'b0;
    unknown_cmd         = 1'b0;
    ddr3_overflow       = 1'b0;
    clear_counts        = 1'b0;
    thres_data_corrupt  = '0;
    thres_unknown_ttc   = '0;
    thres_ddr3_overflow = '0;
    #12;
    reset = 1'b0;

    test_reset();
    test_threshold_trip();
    test_clear_coincident();
    test_simultaneous_trip();
    test_threshold_lower();
    test_idle_counting();
    test_saturation();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
